// File: rtl/miniscope_readout.sv
// miniscope_readout: readout sequencer between the miniscope storage RAM and the DMB stream mux.
//   clock            TMB main clock
//   reset_n          asynchronous active-low reset
//   rd_start_mini    1-cycle readout request, accepted only in IDLE
//   pretrig_adr      RAM write address captured at pre-trigger
//   mini_tbins_pre   tbins read before the pre-trigger
//   mini_rd_tbins    total tbins to read
//   fifo_radr_mini   RAM read address (RAM data returns one clock later)
//   fifo_rdata_mini  RAM read data
//   parity_err_mini  per-byte parity error, aligned with fifo_rdata_mini
//   mini_data        stream word (zero when not valid)
//   mini_data_vld    stream word valid
//   mini_busy        readout in progress
//   mini_done        1-cycle pulse after the last stream word
//   mini_perr        sticky parity flags for the current/last readout
module miniscope_readout #(
   parameter int         RAM_ADRB = 11,
   parameter int         MXTBIN   = 5,
   parameter logic [3:0] HDR_MARK = 4'hA
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                rd_start_mini,
   input  logic [RAM_ADRB-1:0] pretrig_adr,
   input  logic [MXTBIN-1:0]   mini_tbins_pre,
   input  logic [MXTBIN-1:0]   mini_rd_tbins,
   output logic [RAM_ADRB-1:0] fifo_radr_mini,
   input  logic [15:0]         fifo_rdata_mini,
   input  logic [1:0]          parity_err_mini,
   output logic [15:0]         mini_data,
   output logic                mini_data_vld,
   output logic                mini_busy,
   output logic                mini_done,
   output logic [1:0]          mini_perr
);
   typedef enum logic [2:0] {IDLE, HDR, READ, LAST, DONE} state_t;
   state_t state, state_nx;
   logic [MXTBIN-1:0]   cnt, cnt_nx;
   logic [RAM_ADRB-1:0] radr_nx;
   logic [15:0]         data_nx;
   logic                vld_nx, busy_nx, done_nx;
   logic [1:0]          perr_nx;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state          <= IDLE;
         cnt            <= '0;
         fifo_radr_mini <= '0;
         mini_data      <= '0;
         mini_data_vld  <= 1'b0;
         mini_busy      <= 1'b0;
         mini_done      <= 1'b0;
         mini_perr      <= 2'b00;
      end else begin
         state          <= state_nx;
         cnt            <= cnt_nx;
         fifo_radr_mini <= radr_nx;
         mini_data      <= data_nx;
         mini_data_vld  <= vld_nx;
         mini_busy      <= busy_nx;
         mini_done      <= done_nx;
         mini_perr      <= perr_nx;
      end
   // cnt holds the tbin count in HDR, then the number of words still to capture in READ.
   // Address advances only while more than two words remain, so it parks on start+n-1.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      radr_nx  = fifo_radr_mini;
      data_nx  = '0;
      vld_nx   = 1'b0;
      busy_nx  = mini_busy;
      done_nx  = 1'b0;
      perr_nx  = mini_perr;
      case (state)
         IDLE: if (rd_start_mini) begin
            radr_nx  = pretrig_adr - RAM_ADRB'(mini_tbins_pre);
            cnt_nx   = mini_rd_tbins;
            perr_nx  = 2'b00;
            busy_nx  = 1'b1;
            state_nx = HDR;
         end
         HDR: begin
            data_nx  = {HDR_MARK, 12'(cnt)};
            vld_nx   = 1'b1;
            radr_nx  = (cnt >= MXTBIN'(2)) ? fifo_radr_mini + RAM_ADRB'(1) : fifo_radr_mini;
            state_nx = (cnt == '0) ? DONE : (cnt == MXTBIN'(1)) ? LAST : READ;
         end
         READ: begin
            data_nx  = fifo_rdata_mini;
            vld_nx   = 1'b1;
            perr_nx  = mini_perr | parity_err_mini;
            radr_nx  = (cnt >= MXTBIN'(3)) ? fifo_radr_mini + RAM_ADRB'(1) : fifo_radr_mini;
            cnt_nx   = cnt - MXTBIN'(1);
            state_nx = (cnt == MXTBIN'(2)) ? LAST : READ;
         end
         LAST: begin
            data_nx  = fifo_rdata_mini;
            vld_nx   = 1'b1;
            perr_nx  = mini_perr | parity_err_mini;
            state_nx = DONE;
         end
         DONE: begin
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: doc/miniscope_readout.md
Name: miniscope_readout

Overview:
- Readout sequencer directly downstream of the miniscope storage RAM.
- On a readout request it computes the start address from the pre-trigger write address, then walks the RAM read port for a programmed number of tbins.
- It emits one header word followed by the tbin data words into the DMB data stream, and latches any RAM parity errors seen during the walk.
- It sits between the miniscope RAM and the DMB sequencer's stream multiplexer.

Parameters:
- RAM_ADRB, 11, miniscope RAM address width; addresses wrap modulo 2^RAM_ADRB.
- MXTBIN, 5, width of the tbin count and pre-trigger offset fields.
- HDR_MARK, 4'hA, marker nibble placed in header bits [15:12].

Ports:
- clock  in  1  TMB 40MHz main clock.
- reset_n  in  1  asynchronous, active-low reset.
- rd_start_mini  in  1  1-cycle readout request.
- pretrig_adr  in  RAM_ADRB  RAM write address captured at pre-trigger.
- mini_tbins_pre  in  MXTBIN  tbins to read before the pre-trigger.
- mini_rd_tbins  in  MXTBIN  total tbins to read (0 to 31).
- fifo_radr_mini  out  RAM_ADRB  RAM read address; the RAM returns data 1 clock after the address.
- fifo_rdata_mini  in  16  RAM read data.
- parity_err_mini  in  2  per-byte parity error, valid alongside fifo_rdata_mini.
- mini_data  out  16  stream word.
- mini_data_vld  out  1  stream word valid.
- mini_busy  out  1  readout in progress.
- mini_done  out  1  1-cycle pulse at end of readout.
- mini_perr  out  2  sticky parity error flags for the current/last readout.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE. fifo_radr_mini=0, mini_data=0, mini_data_vld=0, mini_busy=0, mini_done=0, mini_perr=0. Reset takes effect immediately even mid-readout; no done pulse is issued and no partial words follow.
- All outputs are registered.
- States: IDLE, HDR, READ, LAST, DONE.
- IDLE:
  - rd_start_mini=1 at edge E1 has these effects:
    - fifo_radr_mini <= (pretrig_adr - mini_tbins_pre) mod 2^RAM_ADRB.
    - The tbin count is latched.
    - mini_perr <= 0.
    - mini_busy <= 1.
    - Go to HDR.
  - rd_start_mini while not IDLE is ignored.
- HDR:
  - At E2: mini_data <= {HDR_MARK, 7'b0, tbins[4:0]} and mini_data_vld <= 1.
  - If tbins=0: go to DONE, mini_busy stays 1 through this header cycle, and no RAM reads are used.
  - Otherwise fifo_radr_mini increments each edge, wrapping from 2^RAM_ADRB-1 to 0, and the state goes to READ.
- READ:
  - The address for tbin i is presented from edge E1+i.
  - At edge E3+i: mini_data <= fifo_rdata_mini and mini_data_vld=1; at the same edge mini_perr <= mini_perr | parity_err_mini.
  - The address stops advancing after start+n-1 (n = tbins).
  - After the final address is issued, go to LAST so the final RAM word can be captured.
- LAST: captures the final word at E2+n, then goes to DONE.
- DONE (one cycle): mini_data_vld=0, mini_data=0, mini_busy=0, mini_done=1; return to IDLE.
- Stream shape: mini_data_vld is high for exactly n+1 consecutive cycles, E2 through E2+n, with no gaps.
- mini_done pulses in the cycle after the last valid word.
- Total latency from request to done pulse: n+2 clocks.
- mini_perr holds its value until the next accepted start.
- mini_data is 0 whenever mini_data_vld=0.
- Arithmetic: the start subtraction is modulo 2^RAM_ADRB, with the pre-trigger offset zero-extended. The count decrement never underflows, and tbins=0 is a legal case.
- rd_start_mini arriving in the DONE cycle is ignored; the next start is accepted from IDLE.

Test Plan:
- pretrig_adr=100, tbins_pre=4, rd_tbins=8, RAM preloaded with data=address -> header 16'hA008, then words 96..103 on 9 consecutive valid cycles; done pulse 1 cycle later; mini_perr=00.
- Wrap case: pretrig_adr=2, tbins_pre=5, rd_tbins=6 -> reads addresses 2045, 2046, 2047, 0, 1, 2 in that order.
- rd_tbins=0 -> single header word 16'hA000, done pulse in the following cycle, fifo_radr_mini not advanced.
- Force parity_err_mini=2'b10 on the 3rd data word only -> mini_perr=10 after done and held; the next start clears it to 00.
- Assert rd_start_mini repeatedly during busy -> ignored; exactly one header+n stream; the back-to-back start after done is accepted normally.
- Deassert reset_n mid-READ (tbin 3 of 8) -> all outputs 0 immediately with no done pulse; a subsequent start produces a complete stream.
